// File: rtl/mem_arbiter.sv
// Round-robin arbiter that multiplexes several cache clients onto one physical
// memory port, keeping exactly one line transaction outstanding at a time.
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata
);

  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORTS - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last_grant;
  logic                    r_pmem_read;
  logic                    r_pmem_write;
  logic [ADDR_WIDTH-1:0]   r_pmem_address;
  logic [LINE_WIDTH-1:0]   r_pmem_wdata;

  logic [NUM_PORTS-1:0]    w_requesting;
  logic [GW-1:0]           w_scan;
  logic [GW-1:0]           w_pick;
  logic                    w_found;

  assign w_requesting = req_read | req_write;

  // Scan starts one past the last grant; the wrap is an explicit compare so
  // non-power-of-two port counts never alias onto a nonexistent client.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = r_last_grant;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      w_scan = (w_scan == LAST_IDX) ? '0 : w_scan + 1'b1;
      if (!w_found && w_requesting[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)   w_state_nxt = BUSY;
      BUSY:    if (pmem_resp) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request fields are captured only on the grant edge, so any later change
  // on the client inputs is invisible until the transaction completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant        <= '0;
      r_last_grant   <= LAST_IDX;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else if (r_state == IDLE && w_found) begin
      r_grant        <= w_pick;
      r_pmem_write   <= req_write[w_pick];
      r_pmem_read    <= ~req_write[w_pick];
      r_pmem_address <= req_address[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
      r_pmem_wdata   <= req_wdata[int'(w_pick)*LINE_WIDTH +: LINE_WIDTH];
    end else if (r_state == BUSY && pmem_resp) begin
      r_last_grant   <= r_grant;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
    end
  end

  always_comb begin
    req_resp = '0;
    if (r_state == BUSY && rst_n) req_resp[r_grant] = pmem_resp;
  end

  assign req_rdata    = pmem_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a queue-free behavioural model.
module tb_mem_arbiter;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       req_read;
  logic [NP-1:0]       req_write;
  logic [NP*AW-1:0]    req_address;
  logic [NP*LW-1:0]    req_wdata;
  logic [NP-1:0]       req_resp;
  logic [LW-1:0]       req_rdata;
  logic                pmem_read;
  logic                pmem_write;
  logic [AW-1:0]       pmem_address;
  logic [LW-1:0]       pmem_wdata;
  logic                pmem_resp;
  logic [LW-1:0]       pmem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_resp    (req_resp),
    .req_rdata   (req_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    req_address[p*AW +: AW] = a;
  endtask

  task automatic set_wdata(input int p, input logic [LW-1:0] d);
    req_wdata[p*LW +: LW] = d;
  endtask

  // Behavioural model: one outstanding job, chosen as the first requester in
  // the cyclic order last+1, last+2, ... (mod NP).
  bit          m_busy;
  bit          m_rd;
  bit          m_wr;
  bit          m_fresh;
  int          m_grant;
  int          m_last;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  always @(posedge clk) begin : model
    int pick;
    int c;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_rd    = 1'b0;
      m_wr    = 1'b0;
      m_fresh = 1'b1;
      m_grant = 0;
      m_last  = NP - 1;
      m_addr  = '0;
      m_wdata = '0;
    end else if (!m_busy) begin
      pick = -1;
      for (int k = 1; k <= NP; k++) begin
        c = (m_last + k) % NP;
        if (pick < 0 && (req_read[c] || req_write[c])) pick = c;
      end
      if (pick >= 0) begin
        m_busy  = 1'b1;
        m_fresh = 1'b0;
        m_grant = pick;
        m_wr    = req_write[pick];
        m_rd    = !req_write[pick];
        m_addr  = req_address[pick*AW +: AW];
        m_wdata = req_wdata[pick*LW +: LW];
      end
    end else if (pmem_resp) begin
      m_busy = 1'b0;
      m_last = m_grant;
      m_rd   = 1'b0;
      m_wr   = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [LW-1:0] exp_resp;
    if (chk_en) begin
      exp_resp = (rst_n && m_busy && pmem_resp) ? (LW'(1) << m_grant) : '0;
      chk("m_req_resp", LW'(req_resp), exp_resp);
      chk("m_req_rdata", req_rdata, pmem_rdata);
      chk("m_pmem_read", LW'(pmem_read), LW'(m_rd));
      chk("m_pmem_write", LW'(pmem_write), LW'(m_wr));
      if (m_rd || m_wr || m_fresh) begin
        chk("m_pmem_address", LW'(pmem_address), LW'(m_addr));
        chk("m_pmem_wdata", pmem_wdata, m_wdata);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_wdata   = '0;
    pmem_resp   = 1'b1;
    pmem_rdata  = '0;

    // Reset state, with pmem_resp high to show it is ignored
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_pmem_read", LW'(pmem_read), '0);
    chk("rst_pmem_write", LW'(pmem_write), '0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chk("rst_req_resp", LW'(req_resp), '0);
    pmem_resp = 1'b0;
    rst_n     = 1'b1;

    // Single read on port 1
    set_addr(1, 16'h1230);
    req_read = 3'b010;
    tick();
    chk("rd_pmem_read", LW'(pmem_read), LW'(1));
    chk("rd_pmem_write", LW'(pmem_write), '0);
    chk("rd_pmem_address", LW'(pmem_address), LW'(16'h1230));
    tick();
    tick();
    pmem_rdata = {16{8'hA5}};
    pmem_resp  = 1'b1;
    #1;
    chk("rd_req_resp", LW'(req_resp), LW'(3'b010));
    chk("rd_req_rdata", req_rdata, {16{8'hA5}});
    tick();
    pmem_resp = 1'b0;
    req_read  = '0;
    chk("rd_done_read", LW'(pmem_read), '0);
    tick();

    // Contention between ports 0 and 1 from reset: order 0,1,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_addr(0, 16'h0100);
    set_addr(1, 16'h0200);
    req_read = 3'b011;
    for (int t = 0; t < 3; t++) begin
      int ord;
      ord = (t == 1) ? 1 : 0;
      tick();
      chk("cont_address", LW'(pmem_address), LW'((ord == 0) ? 16'h0100 : 16'h0200));
      pmem_resp = 1'b1;
      #1;
      chk("cont_req_resp", LW'(req_resp), LW'(1) << ord);
      tick();
      pmem_resp = 1'b0;
    end
    req_read = '0;
    tick();

    // Write on port 0, held until completion
    set_addr(0, 16'h0040);
    set_wdata(0, {32{4'h1}});
    req_write = 3'b001;
    tick();
    chk("wr_pmem_write", LW'(pmem_write), LW'(1));
    chk("wr_pmem_read", LW'(pmem_read), '0);
    chk("wr_pmem_wdata", pmem_wdata, {32{4'h1}});
    tick();
    tick();
    chk("wr_hold_write", LW'(pmem_write), LW'(1));
    chk("wr_hold_wdata", pmem_wdata, {32{4'h1}});
    chk("wr_hold_address", LW'(pmem_address), LW'(16'h0040));
    pmem_resp = 1'b1;
    #1;
    chk("wr_req_resp", LW'(req_resp), LW'(3'b001));
    tick();
    pmem_resp = 1'b0;
    req_write = '0;
    chk("wr_resp_once", LW'(req_resp), '0);
    chk("wr_done_write", LW'(pmem_write), '0);

    // Read and write together on port 1 is a write
    req_read  = 3'b010;
    req_write = 3'b010;
    tick();
    chk("rw_pmem_write", LW'(pmem_write), LW'(1));
    chk("rw_pmem_read", LW'(pmem_read), '0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    req_read  = '0;
    req_write = '0;
    tick();

    // Reset two cycles into a read on port 2
    set_addr(2, 16'h0300);
    req_read = 3'b100;
    tick();
    tick();
    rst_n     = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("rstb_req_resp", LW'(req_resp), '0);
    tick();
    chk("rstb_pmem_read", LW'(pmem_read), '0);
    req_read = '0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rstb_late_resp", LW'(req_resp), '0);
    tick();
    pmem_resp = 1'b0;
    set_addr(0, 16'h0100);
    set_addr(1, 16'h0200);
    req_read = 3'b111;
    tick();
    chk("rstb_port0_wins", LW'(pmem_address), LW'(16'h0100));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    req_read  = '0;
    tick();

    // All three ports continuously requesting: 0,1,2,0,1,2
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    req_read = 3'b111;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("rr3_address", LW'(pmem_address), LW'(16'h0100 * (t % 3 + 1)));
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
    end
    req_read = '0;
    tick();

    // Randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req_read  = NP'($urandom);
      req_write = NP'($urandom & $urandom);
      for (int p = 0; p < NP; p++) begin
        set_addr(p, AW'($urandom));
        set_wdata(p, {$urandom, $urandom, $urandom, $urandom});
      end
      pmem_resp  = ($urandom_range(0, 2) == 0);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting clients (I-cache, D-cache, ...), range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 16, physical address width.
REQ-003 Parameter LINE_WIDTH, default 128, cache-line data width.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port req_read  input  NUM_PORTS  per-client line read request, bit i = client i.
REQ-007 Port req_write  input  NUM_PORTS  per-client line write request.
REQ-008 Port req_address  input  NUM_PORTS*ADDR_WIDTH  client i address in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port req_wdata  input  NUM_PORTS*LINE_WIDTH  client i write line, sliced as above.
REQ-010 Port req_resp  output  NUM_PORTS  per-client completion strobe.
REQ-011 Port req_rdata  output  LINE_WIDTH  read line, broadcast to all clients.
REQ-012 Port pmem_read, pmem_write  output  1 each  physical memory strobes.
REQ-013 Port pmem_address  output  ADDR_WIDTH  physical memory address.
REQ-014 Port pmem_wdata  output  LINE_WIDTH  physical memory write line.
REQ-015 Port pmem_resp  input  1  physical memory completion.
REQ-016 Port pmem_rdata  input  LINE_WIDTH  physical memory read line.

Function
REQ-017 Two states: IDLE, BUSY; one transaction outstanding to pmem at a time.
REQ-018 Client i is requesting when req_read[i] | req_write[i].
REQ-019 IDLE with no client requesting: stay IDLE, pmem_read = pmem_write = 0.
REQ-020 IDLE with >=1 client requesting: grant by round-robin, searching from (last_grant+1) mod NUM_PORTS upward with wrap; register grant, address, wdata, op; next state BUSY.
REQ-021 pmem_read, pmem_write, pmem_address, pmem_wdata are registered; they assert in the first BUSY cycle (1-cycle latency from request sampled in IDLE) and hold constant throughout BUSY.
REQ-022 Client asserting both req_read and req_write is treated as write (pmem_write=1, pmem_read=0).
REQ-023 In BUSY, req_resp[grant] = pmem_resp combinationally; all other req_resp bits = 0; req_rdata = pmem_rdata at all times.
REQ-024 BUSY with pmem_resp=1: next state IDLE, last_grant <= grant, pmem strobes 0 next cycle.
REQ-025 BUSY with pmem_resp=0: stay BUSY; changes on any req_* input (including granted client dropping its request) ignored until completion.
REQ-026 Clients deassert their request in the cycle after req_resp; a request still held in the following IDLE cycle is re-arbitrated as a new transaction.
REQ-027 pmem_resp while IDLE is ignored; no req_resp asserts.
REQ-028 Fairness: a continuously requesting client is granted within NUM_PORTS transactions.
REQ-029 NUM_PORTS not a power of two: pointer wrap uses explicit compare to NUM_PORTS-1, never width overflow.

Reset
REQ-030 rst_n=0 at a rising edge: state IDLE, last_grant = NUM_PORTS-1 (so port 0 has first priority), grant = 0, pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.
REQ-031 Reset during BUSY abandons the transaction: no req_resp issued for it, strobes low next cycle; pmem_resp arriving after reset is ignored per REQ-027.
REQ-032 req_resp = 0 for all clients while in reset.

Verification
REQ-033 Single read: NUM_PORTS=2, port 1 req_read, address 0x1230 -> pmem_read=1, pmem_address=0x1230 next cycle; pmem_resp after 3 cycles with rdata 0xA5..A5 -> req_resp=2'b10 same cycle, req_rdata=0xA5..A5.
REQ-034 Contention: ports 0 and 1 request together from reset -> port 0 served first, port 1 second, port 0 (still requesting) third; grant order 0,1,0.
REQ-035 Write: port 0 req_write, address 0x0040, wdata 0x1111..1111 -> pmem_write=1, pmem_read=0, pmem_wdata=0x1111..1111 held until pmem_resp; req_resp[0] pulses once.
REQ-036 Read+write same port: req_read=req_write=1 on port 1 -> pmem_write=1 only.
REQ-037 Reset mid-BUSY: rst_n low 2 cycles into a read -> pmem_read=0 next cycle, no req_resp; subsequent pmem_resp produces no req_resp; port 0 wins next arbitration.
REQ-038 NUM_PORTS=3, all three requesting continuously -> grants 0,1,2,0,1,2; no client starved.
